// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit: EX-stage operand forwarding selects and load-use stall for the integer pipe
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   hold            1 = freeze every register (memory wait)
//   flush           branch redirect, kills the ID instruction on its way into EX
//   id_*            ID-stage instruction: sources, use flags, destination, write/load flags
//   stall           combinational load-use stall toward fetch/decode
//   forward_a/b     registered EX operand selects: 2 = EX/MEM, 1 = write-back, 0 = register file
//   stall_count     saturating count of load-use stall cycles
module forward_hazard_unit #(
    parameter int RAW  = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hold,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [RAW-1:0]  id_rs,
    input  logic [RAW-1:0]  id_rt,
    input  logic            id_rs_used,
    input  logic            id_rt_used,
    input  logic [RAW-1:0]  id_rd,
    input  logic            id_we,
    input  logic            id_is_load,
    output logic            stall,
    output logic [1:0]      forward_a,
    output logic [1:0]      forward_b,
    output logic [CNTW-1:0] stall_count
);
    logic           ex_v, ex_we, ex_ld, mem_v, mem_we;
    logic [RAW-1:0] ex_rd, mem_rd;
    logic           ex_live, mem_live, bubble;
    logic [1:0]     fwd_a_nx, fwd_b_nx;
    always_comb begin
        ex_live  = ex_v && ex_we && ex_rd != '0;
        mem_live = mem_v && mem_we && mem_rd != '0;
        stall    = id_valid && ex_live && ex_ld && !flush &&
                   ((id_rs_used && id_rs == ex_rd) || (id_rt_used && id_rt == ex_rd));
        bubble   = flush || stall || !id_valid;
        // a matching EX load always stalls, so it never reaches EX as a 2'd2 source
        fwd_a_nx = (!id_rs_used || id_rs == '0) ? 2'd0 :
                   (ex_live && id_rs == ex_rd)   ? 2'd2 :
                   (mem_live && id_rs == mem_rd) ? 2'd1 : 2'd0;
        fwd_b_nx = (!id_rt_used || id_rt == '0) ? 2'd0 :
                   (ex_live && id_rt == ex_rd)   ? 2'd2 :
                   (mem_live && id_rt == mem_rd) ? 2'd1 : 2'd0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v        <= 1'b0;
            ex_rd       <= '0;
            ex_we       <= 1'b0;
            ex_ld       <= 1'b0;
            mem_v       <= 1'b0;
            mem_rd      <= '0;
            mem_we      <= 1'b0;
            forward_a   <= 2'd0;
            forward_b   <= 2'd0;
            stall_count <= '0;
        end else if (!hold) begin
            ex_v      <= !bubble;
            ex_rd     <= id_rd;
            ex_we     <= id_we;
            ex_ld     <= id_is_load;
            mem_v     <= ex_v;
            mem_rd    <= ex_rd;
            mem_we    <= ex_we;
            forward_a <= bubble ? 2'd0 : fwd_a_nx;
            forward_b <= bubble ? 2'd0 : fwd_b_nx;
            if (stall && stall_count != '1)
                stall_count <= stall_count + CNTW'(1);
        end
    end
endmodule
